// File: rtl/fma16_postproc.sv
// Normalize/round/pack stage for the fma16 adder: unrounded sum in, IEEE half result out.
// Define FMA16_NORM_FAST_EN to let NORM take 4-bit left shifts when the top nibble is empty.
module fma16_postproc #(
  parameter int unsigned NORM_CAP  = 40,
  parameter logic [15:0] CANON_NAN = 16'h7E00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Ss,
  input  logic [7:0]  Se,
  input  logic [33:0] Sm,
  input  logic        sticky_in,
  input  logic        in_nan,
  input  logic        in_inf,
  input  logic        in_invalid,
  input  logic [1:0]  roundmode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  localparam int unsigned CntW = $clog2(NORM_CAP + 1);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [33:0]        mant_q, mant_d;
  logic               sticky_q, sticky_d;
  logic               nv_q, nv_d;
  logic [1:0]         rm_q, rm_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [15:0]        result_q, result_d;
  logic [3:0]         flags_q, flags_d;

  // Rounding datapath, only consumed in StRound.
  logic [9:0]         frac_m;
  logic               guard, sticky_all, inc, nx, tiny, ovf;
  logic [11:0]        mant_r;
  logic signed [9:0]  carry_ext, exp_fin;
  logic [15:0]        max_fin, inf_fin;

  always_comb begin
    frac_m     = mant_q[31:22];
    guard      = mant_q[21];
    sticky_all = (|mant_q[20:0]) | sticky_q;
    nx         = guard | sticky_all;
    unique case (rm_q)
      2'b00:   inc = 1'b0;
      2'b01:   inc = guard & (sticky_all | frac_m[0]);
      2'b10:   inc = sign_q & nx;
      default: inc = ~sign_q & nx;
    endcase
    mant_r    = {1'b0, mant_q[32], frac_m} + {11'b0, inc};
    carry_ext = {9'b0, mant_r[11]};
    // Subnormal that rounds up into the hidden bit lands on exponent field 1.
    exp_fin   = mant_q[32] ? (exp_q + carry_ext) : {9'b0, mant_r[10]};
    ovf       = exp_fin >= 10'sd31;
    tiny      = ~mant_q[32] & (mant_q != 34'b0);
    max_fin   = {sign_q, 15'h7BFF};
    inf_fin   = {sign_q, 15'h7C00};
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sticky_d = sticky_q;
    nv_d     = nv_q;
    rm_d     = rm_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d   = Ss;
          exp_d    = {{2{Se[7]}}, Se};
          mant_d   = Sm;
          sticky_d = sticky_in;
          nv_d     = in_invalid;
          rm_d     = roundmode;
          cnt_d    = '0;
          if (in_nan) begin
            result_d = CANON_NAN;
            flags_d  = {in_invalid, 3'b000};
            state_d  = StDone;
          end else if (in_inf) begin
            result_d = {Ss, 5'h1F, 10'h000};
            flags_d  = {in_invalid, 3'b000};
            state_d  = StDone;
          end else begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (mant_q == 34'b0 || cnt_q == CntW'(NORM_CAP)) begin
          state_d = StRound;
        end else if (mant_q[33] || exp_q < 10'sd1) begin
          mant_d   = mant_q >> 1;
          exp_d    = exp_q + 10'sd1;
          sticky_d = sticky_q | mant_q[0];
          cnt_d    = cnt_q + CntW'(1);
        end else if (!mant_q[32] && exp_q > 10'sd1) begin
          cnt_d = cnt_q + CntW'(1);
`ifdef FMA16_NORM_FAST_EN
          if (mant_q[32:29] == 4'b0 && exp_q > 10'sd4) begin
            mant_d = mant_q << 4;
            exp_d  = exp_q - 10'sd4;
          end else begin
            mant_d = mant_q << 1;
            exp_d  = exp_q - 10'sd1;
          end
`else
          mant_d = mant_q << 1;
          exp_d  = exp_q - 10'sd1;
`endif
        end else begin
          state_d = StRound;
        end
      end
      StRound: begin
        state_d = StDone;
        if (mant_q == 34'b0) begin
          result_d = {sign_q, 15'h0000};
          flags_d  = {nv_q, 2'b00, sticky_q};
        end else if (ovf) begin
          unique case (rm_q)
            2'b00:   result_d = max_fin;
            2'b01:   result_d = inf_fin;
            2'b10:   result_d = sign_q ? inf_fin : max_fin;
            default: result_d = sign_q ? max_fin : inf_fin;
          endcase
          flags_d = {nv_q, 1'b1, 1'b0, 1'b1};
        end else begin
          result_d = {sign_q, exp_fin[4:0], mant_r[9:0]};
          flags_d  = {nv_q, 1'b0, tiny & nx, nx};
        end
      end
      default: begin
        if (out_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      nv_q     <= 1'b0;
      rm_q     <= 2'b00;
      cnt_q    <= '0;
      result_q <= 16'h0000;
      flags_q  <= 4'h0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      sticky_q <= sticky_d;
      nv_q     <= nv_d;
      rm_q     <= rm_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule
